// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for the 5-stage RV32I pipeline: owns PCF, runs a
// single-outstanding req/gnt/rvalid handshake and drives the IF/ID register.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] hold_buf;
  logic        deliver;
  logic        capture;
  logic [31:0] deliver_word;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;

  assign redirect_pc = {PCTargetE[31:2], 2'b00};
  assign pc_plus4    = PCF + 32'd4;
  assign imem_req    = (state == S_REQ) && !rst;
  assign imem_addr   = PCF;

  always_comb begin
    state_next   = state;
    deliver      = 1'b0;
    capture      = 1'b0;
    deliver_word = imem_rdata;

    if (PCSrcE) begin
      // A granted but unanswered request must still be drained, so the
      // redirect parks in DISCARD until its stale response shows up.
      unique case (state)
        S_REQ:     state_next = imem_gnt    ? S_DISCARD : S_REQ;
        S_WAIT:    state_next = imem_rvalid ? S_REQ     : S_DISCARD;
        S_HOLD:    state_next = S_REQ;
        S_DISCARD: state_next = imem_rvalid ? S_REQ     : S_DISCARD;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_gnt) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (StallF) begin
              capture    = 1'b1;
              state_next = S_HOLD;
            end else begin
              deliver    = 1'b1;
              state_next = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!StallF) begin
            deliver      = 1'b1;
            deliver_word = hold_buf;
            state_next   = S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid) state_next = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      PCF      <= RESET_PC;
      hold_buf <= '0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) hold_buf <= imem_rdata;

      if (PCSrcE) begin
        PCF    <= redirect_pc;
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end else if (deliver) begin
        InstrD   <= deliver_word;
        PCD      <= PCF;
        PCPlus4D <= pc_plus4;
        ValidD   <= 1'b1;
        PCF      <= pc_plus4;
      end else if (!StallF) begin
        ValidD <= 1'b0;
      end
    end
  end

endmodule
